color_convert_mul_arbiter: RTL
==============================

# color_convert_mul_arbiter

Round-robin scheduler that shares one signed-by-unsigned multiplier (10-bit signed × 8-bit unsigned → 18-bit signed) among several coefficient lanes of the RGB→YCbCr color-convert datapath. The multiplier itself stays external and combinational. This block picks one requester per cycle, drives the multiplier operands, and captures the product. It returns the product with the requester's index over a valid/ready response port. Full throughput is one product per cycle, with backpressure.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DIN0_WIDTH, 10, signed operand width
- DIN1_WIDTH, 8, unsigned operand width
- DOUT_WIDTH, 18, product width (DIN0_WIDTH+DIN1_WIDTH)
- ID_WIDTH, 2, width of requester index (clog2(NUM_REQ), min 1)

Ports:
- ap_clk  in  1  clock; all state updates on rising edge
- ap_rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  one-hot grant; transfer on req_valid[i] & req_ready[i]
- req_din0  in  NUM_REQ*DIN0_WIDTH  signed operands, lane i at [i*DIN0_WIDTH +: DIN0_WIDTH]
- req_din1  in  NUM_REQ*DIN1_WIDTH  unsigned operands, same packing
- mul_din0  out  DIN0_WIDTH  operand to external multiplier
- mul_din1  out  DIN1_WIDTH  operand to external multiplier
- mul_dout  in  DOUT_WIDTH  product from external multiplier, combinational from mul_din0/1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_WIDTH  index of requester that produced rsp_data
- rsp_data  out  DOUT_WIDTH  signed product

## Operation
- Round-robin pointer `last` holds the most recently granted index. Reset value is NUM_REQ-1, so requester 0 wins first.
- Grant goes to the first i with req_valid[i], searching from last+1 upward and wrapping modulo NUM_REQ. `last` updates only on an actual transfer.
- A grant is issued only when the issue slot can advance: `slot_free = !stage_full | (rsp_valid & rsp_ready)`. Otherwise req_ready is all zero.
- req_ready depends combinationally on req_valid, `last` and slot state. It never asserts for a lane whose req_valid is low, and at most one bit is set.
- On grant, mul_din0/mul_din1 carry the granted lane's operands. With no grant they are driven to 0. They never pass X to the multiplier.
- Product arithmetic: signed(din0) × unsigned(din1). The result range is -130560..130305, which fits DOUT_WIDTH=18 exactly. There is no saturation and no truncation.
- The response register (rsp_valid, rsp_id, rsp_data) loads on transfer and holds stable while rsp_valid & !rsp_ready.
- rsp_valid clears on rsp_ready with no new transfer.
- Simultaneous drain and transfer in the same cycle: the register reloads with the new result, rsp_valid stays 1, and there is no bubble.
- No requester starves: with all lanes valid and rsp_ready=1, grants rotate 0,1,2,0,…

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, mul_din0=0, mul_din1=0, `last`=NUM_REQ-1, pipeline stage empty.
- Latency without the macro: transfer at edge T, rsp_valid=1 after edge T (visible in cycle T+1).
- Latency with the macro: see Configuration.
- Throughput: 1 result/cycle while rsp_ready=1.
- ap_rst mid-operation: in-flight operands and results are discarded. Outputs return to reset values on the next edge. Requesters must re-present.
- While ap_rst=1, req_ready=0. No transfer occurs in a reset cycle.

## Configuration
- COLOR_CONVERT_MUL_ARB_PIPE_EN defined:
  - An operand register sits between the arbiter and mul_din0/mul_din1, so the multiplier sees registered operands. This is for timing closure on DSP input.
  - Latency is 2: transfer at edge T, rsp_valid after edge T+1.
  - The operand stage and response register form a 2-deep pipeline with full backpressure. The operand stage advances only if the response register is empty or draining.
  - `slot_free` refers to the operand stage.
  - mul_din0/1 hold their value while the operand stage is stalled.
- Not defined:
  - Operands pass combinationally from the granted lane.
  - Latency 1, single stage as above.

## Test plan
- Single request: req_valid=3'b001, din0=-512, din1=255, rsp_ready=1 → req_ready=3'b001 for one cycle; rsp_data=-130560 (18'h20200), rsp_id=0 after 1 cycle (2 with PIPE_EN).
- Fairness: all three valid continuously, rsp_ready=1, operands lane i = (i+1, 10) → rsp_id sequence 0,1,2,0,1,2; rsp_data 10,20,30 repeating; no idle cycles.
- Backpressure: all valid, rsp_ready=0 for 5 cycles → exactly 1 transfer (2 with PIPE_EN); rsp_data/rsp_id stable; on rsp_ready=1, back-to-back resumption with no lost or duplicated result.
- Boundary products: (511,255) → 130305; (-1,0) → 0; (-1,1) → -1 (18'h3FFFF), all returned with correct id.
- Reset mid-stream: assert ap_rst for 1 cycle while rsp_valid=1 → next cycle rsp_valid=0, req_ready=0 during reset; first grant after reset goes to lane 0.
- Sparse requests: only lane 2 valid, then only lane 1 → grants 2, then 1; pointer wrap from 2 to 0 verified with lanes 0 and 2 alternating.

Source files
------------

// File: rtl/color_convert_mul_arbiter_if.sv
// rtl/color_convert_mul_arbiter_if.sv - requester, multiplier and response signals of the shared-multiplier arbiter
interface color_convert_mul_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DIN0_WIDTH = 10,
    parameter int DIN1_WIDTH = 8,
    parameter int DOUT_WIDTH = 18,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
    logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
    logic [DIN0_WIDTH-1:0]         mul_din0;
    logic [DIN1_WIDTH-1:0]         mul_din1;
    logic [DOUT_WIDTH-1:0]         mul_dout;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic [DOUT_WIDTH-1:0]         rsp_data;

    modport slave (
        input  req_valid, req_din0, req_din1, mul_dout, rsp_ready,
        output req_ready, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_din0, req_din1, mul_dout, rsp_ready,
        input  req_ready, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/color_convert_mul_arbiter.sv
// rtl/color_convert_mul_arbiter.sv - round-robin sharing of one external signed x unsigned multiplier
// Optional operand register stage: COLOR_CONVERT_MUL_ARB_PIPE_EN.
module color_convert_mul_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DIN0_WIDTH = 10,
    parameter int DIN1_WIDTH = 8,
    parameter int DOUT_WIDTH = 18,
    parameter int ID_WIDTH   = 2
) (
    input logic                    ap_clk,
    input logic                    ap_rst,
    color_convert_mul_arbiter_if.slave bus
);
    localparam logic [ID_WIDTH-1:0] LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

    logic [ID_WIDTH-1:0]   last;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  grant_hit;
    logic                  slot_free;
    logic                  fire;
    logic [NUM_REQ-1:0]    ready;
    logic [DIN0_WIDTH-1:0] sel_din0;
    logic [DIN1_WIDTH-1:0] sel_din1;

    logic                  rsp_valid_q;
    logic [ID_WIDTH-1:0]   rsp_id_q;
    logic [DOUT_WIDTH-1:0] rsp_data_q;

    // Search starts one past the last winner and wraps modulo NUM_REQ.
    always_comb begin
        int cand;
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_hit && bus.req_valid[cand]) begin
                grant_hit = 1'b1;
                grant_idx = ID_WIDTH'(cand);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (grant_hit && slot_free && !ap_rst) begin
            ready = NUM_REQ'(1) << grant_idx;
        end
    end

    assign fire          = |ready;
    assign bus.req_ready = ready;
    assign sel_din0      = bus.req_din0[int'(grant_idx)*DIN0_WIDTH +: DIN0_WIDTH];
    assign sel_din1      = bus.req_din1[int'(grant_idx)*DIN1_WIDTH +: DIN1_WIDTH];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            last <= LAST_INIT;
        end else if (fire) begin
            last <= grant_idx;
        end
    end

`ifdef COLOR_CONVERT_MUL_ARB_PIPE_EN
    logic                  op_valid;
    logic [ID_WIDTH-1:0]   op_id;
    logic [DIN0_WIDTH-1:0] op_din0;
    logic [DIN1_WIDTH-1:0] op_din1;
    logic                  rsp_adv;

    // The operand stage may only move when the response register can take its product.
    assign rsp_adv      = !rsp_valid_q || bus.rsp_ready;
    assign slot_free    = !op_valid || rsp_adv;
    assign bus.mul_din0 = op_din0;
    assign bus.mul_din1 = op_din1;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            op_valid <= 1'b0;
            op_id    <= '0;
            op_din0  <= '0;
            op_din1  <= '0;
        end else if (slot_free) begin
            op_valid <= fire;
            op_id    <= grant_idx;
            op_din0  <= fire ? sel_din0 : '0;
            op_din1  <= fire ? sel_din1 : '0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else if (op_valid && rsp_adv) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= op_id;
            rsp_data_q  <= bus.mul_dout;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end
`else
    assign slot_free    = !rsp_valid_q || bus.rsp_ready;
    assign bus.mul_din0 = fire ? sel_din0 : '0;
    assign bus.mul_din1 = fire ? sel_din1 : '0;

    // A drain and a new transfer in the same cycle simply reload the register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else if (fire) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= grant_idx;
            rsp_data_q  <= bus.mul_dout;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end
`endif

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule
